// File: rtl/qspi_pkg.sv
// Constants and FSM encoding shared by the QSPI framebuffer writer and scan-out reader.
package qspi_pkg;

  localparam logic [7:0]  QSPI_CMD_WRITE    = 8'h38;
  localparam int unsigned QSPI_ADDR_W       = 24;
  localparam int unsigned QSPI_ADDR_NIBBLES = QSPI_ADDR_W / 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DESEL
  } qspi_state_t;

  // Nibble idx of a byte address, counting from the most significant nibble.
  function automatic logic [3:0] addr_nibble(input logic [QSPI_ADDR_W-1:0] addr,
                                             input logic [2:0]             idx);
    logic [QSPI_ADDR_W-1:0] shifted;
    shifted = addr << (4 * idx);
    return shifted[QSPI_ADDR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO with flush; push while full is accepted only alongside a pop.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qspi_pixel_writer.sv
// Buffers engine pixels and writes them to QSPI PSRAM as quad-mode bursts,
// borrowing the pins from the scan-out reader via bus_req/bus_grant.
module qspi_pixel_writer
  import qspi_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = 76800,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  CMD_WRITE    = QSPI_CMD_WRITE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pixel_in,
  input  logic       pixel_valid,
  output logic       pixel_ready,
  input  logic       restart,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [3:0] data_dir,
  output logic [3:0] data_out,
  output logic       chip_enable,
  output logic       frame_done
);

  localparam int unsigned PTR_W  = $clog2(FRAME_PIXELS);
  localparam int unsigned CNT_W  = $clog2(BURST_LEN + QSPI_ADDR_NIBBLES);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_BASE = PTR_W'(FRAME_PIXELS - BURST_LEN);

  qspi_state_t            state;
  qspi_state_t            state_n;
  logic [CNT_W-1:0]       nib_cnt;
  logic [PTR_W-1:0]       ptr;
  logic [QSPI_ADDR_W-1:0] byte_addr;
  logic                   last_burst;
  logic                   ptr_adv;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [3:0]             fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FCNT_W-1:0]      fifo_count;

  // Held low during reset so the engine never hands over a pixel that would be lost.
  assign pixel_ready = rst_n && !fifo_full && !restart;
  assign fifo_push   = pixel_valid && pixel_ready;
  assign byte_addr   = QSPI_ADDR_W'(ptr >> 1);
  assign last_burst  = (ptr == LAST_BASE);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (restart),
    .din   (pixel_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n     = state;
    bus_req     = 1'b0;
    chip_enable = 1'b0;
    data_dir    = '0;
    data_out    = '0;
    fifo_pop    = 1'b0;
    frame_done  = 1'b0;
    ptr_adv     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fifo_count >= FCNT_W'(BURST_LEN)) begin
          bus_req = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) state_n = ST_CMD;
      end
      ST_CMD: begin
        bus_req     = 1'b1;
        chip_enable = 1'b1;
        data_dir    = '1;
        data_out    = (nib_cnt == '0) ? CMD_WRITE[7:4] : CMD_WRITE[3:0];
        if (nib_cnt == CNT_W'(1)) state_n = ST_ADDR;
      end
      ST_ADDR: begin
        bus_req     = 1'b1;
        chip_enable = 1'b1;
        data_dir    = '1;
        data_out    = addr_nibble(byte_addr, nib_cnt[2:0]);
        if (nib_cnt == CNT_W'(QSPI_ADDR_NIBBLES - 1)) state_n = ST_DATA;
      end
      ST_DATA: begin
        bus_req     = 1'b1;
        chip_enable = 1'b1;
        data_dir    = '1;
        data_out    = fifo_dout;
        fifo_pop    = 1'b1;
        if (nib_cnt == CNT_W'(BURST_LEN - 1)) state_n = ST_DESEL;
      end
      ST_DESEL: begin
        frame_done = last_burst;
        ptr_adv    = 1'b1;
        state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Restart overrides everything; the flush itself happens inside the FIFO.
    if (restart) begin
      state_n    = ST_IDLE;
      frame_done = 1'b0;
      ptr_adv    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      nib_cnt <= '0;
      ptr     <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        nib_cnt <= '0;
      else if (state inside {ST_CMD, ST_ADDR, ST_DATA})
        nib_cnt <= nib_cnt + 1'b1;

      if (restart)
        ptr <= '0;
      else if (ptr_adv)
        ptr <= last_burst ? '0 : ptr + PTR_W'(BURST_LEN);
    end
  end

endmodule
